// File: rtl/data_memory.sv
// Single-port word memory with a request/ready handshake and configurable read latency.
// Define MEM_PARITY_EN to add a per-word even-parity bit and a par_inject input for error injection.
module data_memory #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
`ifdef MEM_PARITY_EN
  input  logic              par_inject,
`endif
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] adrs,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int DEPTH = 1 << ADDR_W;
  // RD_WAIT is held for RD_LAT-1 cycles; the counter starts at RD_LAT-2 and exits on zero.
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        cnt;
  logic              rd_req, wr_req, collide;
  logic              load_rd, write_en;
  logic [ADDR_W-1:0] rd_addr;
`ifdef MEM_PARITY_EN
  logic              par_mem [DEPTH];
  logic              par_q;
`endif

  assign rd_req    = mem_rd & ~mem_wr;
  assign wr_req    = mem_wr & ~mem_rd;
  assign collide   = (state == IDLE) & mem_rd & mem_wr;
  assign mem_busy  = (state != IDLE);
  assign mem_ready = (state == DONE);
  // With RD_LAT=1 the read is loaded on the accepting edge, so use the live address.
  assign rd_addr   = (state == IDLE) ? adrs : adr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt = state;
    load_rd   = 1'b0;
    write_en  = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          state_nxt = (RD_LAT == 1) ? DONE : RD_WAIT;
          load_rd   = (RD_LAT == 1);
        end else if (wr_req) begin
          state_nxt = WR;
        end
      end
      RD_WAIT: begin
        if (cnt == 2'd0) begin
          state_nxt = DONE;
          load_rd   = 1'b1;
        end
      end
      WR: begin
        write_en  = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the array is in the async reset on purpose -- reset must clear every word at once,
  // which rules out a plain RAM macro for this block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      adr_q   <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      rd_data <= '0;
      mem_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef MEM_PARITY_EN
      par_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
`endif
    end else begin
      mem_err <= collide;
      if (state == IDLE && (rd_req || wr_req)) begin
        adr_q   <= adrs;
        wdata_q <= wr_data;
        cnt     <= CNT_INIT;
`ifdef MEM_PARITY_EN
        par_q   <= (^wr_data) ^ par_inject;
`endif
      end
      if (state == RD_WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
      if (write_en) begin
        mem[adr_q] <= wdata_q;
`ifdef MEM_PARITY_EN
        par_mem[adr_q] <= par_q;
`endif
      end
      if (load_rd) begin
        rd_data <= mem[rd_addr];
`ifdef MEM_PARITY_EN
        mem_err <= (^mem[rd_addr]) != par_mem[rd_addr];
`endif
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized read/write traffic
// checked against an array model of the memory contents and handshake timing.
module tb_data_memory;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              mem_rd = 1'b0;
  logic              mem_wr = 1'b0;
  logic              par_inject = 1'b0;
  logic [ADDR_W-1:0] adrs = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] rd_data;
  logic              mem_ready, mem_busy, mem_err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              ref_bad [DEPTH];
  logic [DATA_W-1:0] ref_rd;

  data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef MEM_PARITY_EN
    .par_inject(par_inject),
`endif
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .adrs      (adrs),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .mem_ready (mem_ready),
    .mem_busy  (mem_busy),
    .mem_err   (mem_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_bad[i] = 1'b0;
    end
    ref_rd = '0;
  endtask

  // All operation tasks start and end at a negedge with the DUT idle.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic inj);
    mem_wr = 1'b1; adrs = a; wr_data = d; par_inject = inj;
    @(posedge clock);
    @(negedge clock);
    mem_wr = 1'b0; par_inject = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      if (i > 1) @(negedge clock);
      checks++;
      if (mem_ready !== (i == 2)) begin
        errors++; $display("FAIL wr_ready a=%0d cyc=%0d got=%b exp=%b", a, i, mem_ready, (i == 2));
      end
      checks++;
      if (mem_busy !== 1'b1) begin
        errors++; $display("FAIL wr_busy a=%0d cyc=%0d got=%b exp=1", a, i, mem_busy);
      end
    end
    checks++;
    if (rd_data !== ref_rd) begin
      errors++; $display("FAIL wr_hold_rd_data got=%h exp=%h", rd_data, ref_rd);
    end
    ref_mem[a] = d;
`ifdef MEM_PARITY_EN
    ref_bad[a] = inj;
`else
    ref_bad[a] = 1'b0;
`endif
    @(negedge clock);
    checks++;
    if (mem_ready !== 1'b0 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL wr_idle ready=%b busy=%b exp=0,0", mem_ready, mem_busy);
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    mem_rd = 1'b1; adrs = a;
    @(posedge clock);
    @(negedge clock);
    mem_rd = 1'b0;
    for (int i = 1; i <= RD_LAT; i++) begin
      if (i > 1) @(negedge clock);
      checks++;
      if (mem_ready !== (i == RD_LAT) || mem_busy !== 1'b1) begin
        errors++;
        $display("FAIL rd_timing a=%0d cyc=%0d ready=%b busy=%b exp=%b,1", a, i, mem_ready, mem_busy, (i == RD_LAT));
      end
    end
    checks++;
    if (rd_data !== ref_mem[a]) begin
      errors++; $display("FAIL rd_data a=%0d got=%h exp=%h", a, rd_data, ref_mem[a]);
    end
    checks++;
    if (mem_err !== ref_bad[a]) begin
      errors++; $display("FAIL rd_err a=%0d got=%b exp=%b", a, mem_err, ref_bad[a]);
    end
    ref_rd = ref_mem[a];
    @(negedge clock);
    checks++;
    if (mem_ready !== 1'b0 || mem_busy !== 1'b0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL rd_idle ready=%b busy=%b err=%b exp=0,0,0", mem_ready, mem_busy, mem_err);
    end
  endtask

  task automatic test_reset();
    model_clear();
    reset = 1'b1;
    #1;
    checks++;
    if (rd_data !== '0 || mem_ready !== 1'b0 || mem_busy !== 1'b0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs rd=%h ready=%b busy=%b err=%b exp=00,0,0,0", rd_data, mem_ready, mem_busy, mem_err);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    do_read(4'd5);
  endtask

  task automatic test_write_read();
    do_write(4'd3, 8'hA5, 1'b0);
    do_read(4'd3);
    do_write(4'd15, 8'h81, 1'b0);
    do_write(4'd0, 8'h7E, 1'b0);
    do_read(4'd15);
    do_read(4'd0);
  endtask

  task automatic test_collision();
    do_write(4'd2, 8'h5A, 1'b0);
    mem_rd = 1'b1; mem_wr = 1'b1; adrs = 4'd2; wr_data = 8'hFF;
    @(posedge clock);
    @(negedge clock);
    mem_rd = 1'b0; mem_wr = 1'b0;
    checks++;
    if (mem_err !== 1'b1 || mem_busy !== 1'b0 || mem_ready !== 1'b0) begin
      errors++; $display("FAIL collide_pulse err=%b busy=%b ready=%b exp=1,0,0", mem_err, mem_busy, mem_ready);
    end
    @(negedge clock);
    checks++;
    if (mem_err !== 1'b0 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL collide_after err=%b busy=%b exp=0,0", mem_err, mem_busy);
    end
    do_read(4'd2);
  endtask

  task automatic test_ignore_busy();
    do_write(4'd7, 8'h3C, 1'b0);
    mem_rd = 1'b1; adrs = 4'd7;
    @(posedge clock);
    @(negedge clock);
    mem_rd = 1'b0;
    mem_wr = 1'b1; wr_data = 8'hC3;
    for (int i = 1; i <= RD_LAT; i++) begin
      if (i > 1) @(negedge clock);
      if (i == 2) mem_wr = 1'b0;
      checks++;
      if (mem_ready !== (i == RD_LAT) || mem_err !== 1'b0) begin
        errors++; $display("FAIL ignore_timing cyc=%0d ready=%b err=%b exp=%b,0", i, mem_ready, mem_err, (i == RD_LAT));
      end
    end
    mem_wr = 1'b0;
    checks++;
    if (rd_data !== 8'h3C) begin
      errors++; $display("FAIL ignore_rd_data got=%h exp=3c", rd_data);
    end
    ref_rd = 8'h3C;
    @(negedge clock);
    checks++;
    if (mem_busy !== 1'b0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL ignore_idle busy=%b err=%b exp=0,0", mem_busy, mem_err);
    end
    do_read(4'd7);
  endtask

  task automatic test_reset_in_wr();
    do_write(4'd9, 8'h11, 1'b0);
    mem_wr = 1'b1; adrs = 4'd9; wr_data = 8'h77;
    @(posedge clock);
    @(negedge clock);
    mem_wr = 1'b0;
    checks++;
    if (mem_busy !== 1'b1) begin
      errors++; $display("FAIL rst_wr_busy got=%b exp=1", mem_busy);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (rd_data !== '0 || mem_ready !== 1'b0 || mem_busy !== 1'b0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_outputs rd=%h ready=%b busy=%b err=%b exp=00,0,0,0", rd_data, mem_ready, mem_busy, mem_err);
    end
    model_clear();
    @(posedge clock);
    #1;
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++; $display("FAIL rst_wr_no_ready got=%b exp=0", mem_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    do_read(4'd9);
    do_read(4'd7);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int op;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic inj;
      op  = $urandom_range(0, 4);
      a   = ADDR_W'($urandom);
      d   = DATA_W'($urandom);
`ifdef MEM_PARITY_EN
      inj = ($urandom_range(0, 3) == 0);
`else
      inj = 1'b0;
`endif
      if (op < 2)       do_read(a);
      else if (op < 4)  do_write(a, d, inj);
      else              @(negedge clock);
    end
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity();
    do_write(4'd6, 8'h0F, 1'b1);
    do_read(4'd6);
    checks++;
    if (rd_data !== 8'h0F) begin
      errors++; $display("FAIL parity_data got=%h exp=0f", rd_data);
    end
    do_write(4'd6, 8'h0F, 1'b0);
    do_read(4'd6);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_ignore_busy();
    test_reset_in_wr();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
